// File: rtl/vga_pkg.sv
// vga_pkg: 1024x768 screen constants, colours and the
// packed timing/rgb bundle carried down the video pipeline.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_tim_t;

endpackage

// File: rtl/vga_if.sv
// vga_if: timing + rgb stream between pipeline stages.
// Modports: in (consumer side), out (producer side).
interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, hcount, vsync,
    input vblnk, hsync, hblnk, rgb
  );

  modport out (
    output vcount, hcount, vsync,
    output vblnk, hsync, hblnk, rgb
  );

endinterface

// File: rtl/delay.sv
// delay: CLK_DEL-stage register pipe (CLK_DEL >= 1).
// Ports: clk, rst_n (async, active-low), din, dout.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_sprite.sv
// draw_sprite: ROM-fed sprite overlay with zoom, mirror, colour key.
// Ports: clk65MHz, rst_n, in_if/out_if, x_pos/y_pos/sprite_en/mirror_x, pixel_addr, rgb_pixel.
module draw_sprite
  import vga_pkg::*;
#(
  parameter int          SPRITE_W    = 48,
  parameter int          SPRITE_H    = 64,
  parameter int          ROM_LATENCY = 1,
  parameter int          SCALE_LOG2  = 0,
  parameter bit          KEY_EN      = 1'b1,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F,
  localparam int XW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int YW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
  localparam int AW = XW + YW
) (
  input  logic          clk65MHz,
  input  logic          rst_n,
  vga_if.in             in_if,
  vga_if.out            out_if,
  input  logic [11:0]   x_pos,
  input  logic [11:0]   y_pos,
  input  logic          sprite_en,
  input  logic          mirror_x,
  output logic [AW-1:0] pixel_addr,
  input  logic [11:0]   rgb_pixel
);

  localparam int LAT = ROM_LATENCY + 2;
  localparam logic [12:0] DW = 13'(SPRITE_W << SCALE_LOG2);
  localparam logic [12:0] DH = 13'(SPRITE_H << SCALE_LOG2);

  logic        vblnk_q;
  logic        frame_start;
  logic [11:0] x_act;
  logic [11:0] y_act;
  logic        en_act;
  logic        mir_act;

  assign frame_start = in_if.vblnk & ~vblnk_q;

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      x_act   <= '0;
      y_act   <= '0;
      en_act  <= 1'b0;
      mir_act <= 1'b0;
    end else begin
      vblnk_q <= in_if.vblnk;
      if (frame_start) begin
        x_act   <= x_pos;
        y_act   <= y_pos;
        en_act  <= sprite_en;
        mir_act <= mirror_x;
      end
    end
  end

  logic [12:0]   h13, v13, x13, y13;
  logic [12:0]   rel_x, rel_y;
  logic [XW-1:0] dx, dx_sel;
  logic [YW-1:0] dy;
  logic          hit;

  assign h13   = {2'b00, in_if.hcount};
  assign v13   = {2'b00, in_if.vcount};
  assign x13   = {1'b0, x_act};
  assign y13   = {1'b0, y_act};
  assign rel_x = h13 - x13;
  assign rel_y = v13 - y13;
  assign dx    = XW'(rel_x >> SCALE_LOG2);
  assign dy    = YW'(rel_y >> SCALE_LOG2);
  assign dx_sel = mir_act ? (XW'(SPRITE_W - 1) - dx) : dx;

  // Visible-area bound clips the sprite at the right/bottom edge.
  assign hit = en_act
            && (h13 >= x13) && (h13 < x13 + DW)
            && (v13 >= y13) && (v13 < y13 + DH)
            && (h13 < 13'(HOR_PIXELS))
            && (v13 < 13'(VER_PIXELS));

  // Address holds on a miss so the ROM output stays quiet.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n)
      pixel_addr <= '0;
    else if (hit)
      pixel_addr <= {dy, dx_sel};
  end

  vga_tim_t tim_in, tim_d, out_nxt, out_q;
  logic     hit_d;
  logic     keyed;

  always_comb begin
    tim_in        = '0;
    tim_in.vcount = in_if.vcount;
    tim_in.hcount = in_if.hcount;
    tim_in.vsync  = in_if.vsync;
    tim_in.vblnk  = in_if.vblnk;
    tim_in.hsync  = in_if.hsync;
    tim_in.hblnk  = in_if.hblnk;
    tim_in.rgb    = in_if.rgb;
  end

  // Last pipe stage is out_q, so the pipe is one short of LAT.
  delay #(
    .WIDTH   ($bits(vga_tim_t)),
    .CLK_DEL (LAT - 1)
  ) u_tim_delay (
    .clk   (clk65MHz),
    .rst_n (rst_n),
    .din   (tim_in),
    .dout  (tim_d)
  );

  // Hit lines up with rgb_pixel, ROM_LATENCY after the address.
  delay #(
    .WIDTH   (1),
    .CLK_DEL (ROM_LATENCY + 1)
  ) u_hit_delay (
    .clk   (clk65MHz),
    .rst_n (rst_n),
    .din   (hit),
    .dout  (hit_d)
  );

  assign keyed = KEY_EN && (rgb_pixel == KEY_COLOR);

  always_comb begin
    out_nxt = tim_d;
    if (tim_d.hblnk || tim_d.vblnk)
      out_nxt.rgb = BLACK;
    else if (hit_d && !keyed)
      out_nxt.rgb = rgb_pixel;
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n)
      out_q <= '0;
    else
      out_q <= out_nxt;
  end

  assign out_if.vcount = out_q.vcount;
  assign out_if.hcount = out_q.hcount;
  assign out_if.vsync  = out_q.vsync;
  assign out_if.vblnk  = out_q.vblnk;
  assign out_if.hsync  = out_q.hsync;
  assign out_if.hblnk  = out_q.hblnk;
  assign out_if.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: directed bench for draw_sprite.
// Three instances: default, zoom x2, ROM latency 3.
module tb_draw_sprite;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] x_pos, y_pos;
  logic        sprite_en, mirror_x;
  logic [11:0] addr0, addr1, addr2;
  logic [11:0] rom0, rom1, rom2a, rom2b, rom2c;

  int n_chk = 0;
  int n_err = 0;

  vga_if in_vif();
  vga_if out0();
  vga_if out1();
  vga_if out2();

  function automatic logic [11:0] rom_word(input logic [11:0] a);
    return a ^ 12'h800;
  endfunction

  always_ff @(posedge clk) begin
    rom0  <= rom_word(addr0);
    rom1  <= rom_word(addr1);
    rom2a <= rom_word(addr2);
    rom2b <= rom2a;
    rom2c <= rom2b;
  end

  draw_sprite u_dut0 (
    .clk65MHz(clk), .rst_n(rst_n),
    .in_if(in_vif), .out_if(out0),
    .x_pos(x_pos), .y_pos(y_pos),
    .sprite_en(sprite_en), .mirror_x(mirror_x),
    .pixel_addr(addr0), .rgb_pixel(rom0)
  );

  draw_sprite #(.SCALE_LOG2(1)) u_dut1 (
    .clk65MHz(clk), .rst_n(rst_n),
    .in_if(in_vif), .out_if(out1),
    .x_pos(x_pos), .y_pos(y_pos),
    .sprite_en(sprite_en), .mirror_x(mirror_x),
    .pixel_addr(addr1), .rgb_pixel(rom1)
  );

  draw_sprite #(.ROM_LATENCY(3)) u_dut2 (
    .clk65MHz(clk), .rst_n(rst_n),
    .in_if(in_vif), .out_if(out2),
    .x_pos(x_pos), .y_pos(y_pos),
    .sprite_en(sprite_en), .mirror_x(mirror_x),
    .pixel_addr(addr2), .rgb_pixel(rom2c)
  );

  typedef struct {
    int          h;
    int          v;
    bit          hit;
    logic [11:0] e;
  } vec_t;

  task automatic drive(input int h, input int v,
                       input logic hb, input logic vb,
                       input logic [11:0] bg);
    in_vif.hcount = 11'(h);
    in_vif.vcount = 11'(v);
    in_vif.hblnk  = hb;
    in_vif.hsync  = hb;
    in_vif.vblnk  = vb;
    in_vif.vsync  = vb;
    in_vif.rgb    = bg;
  endtask

  task automatic latch_frame();
    drive(0, 768, 1'b1, 1'b1, 12'h000);
    repeat (2) @(negedge clk);
    drive(1100, 0, 1'b1, 1'b0, 12'h000);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1100, 0, 1'b1, 1'b0, 12'h000);
    x_pos = 0; y_pos = 0;
    sprite_en = 1'b0; mirror_x = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_chk++; if (out0.rgb !== 12'h000) begin n_err++;
      $display("FAIL reset rgb: got %h want 000", out0.rgb); end
    n_chk++; if (out0.hcount !== 11'd0) begin n_err++;
      $display("FAIL reset hcount: got %0d want 0", out0.hcount); end
    n_chk++; if (out0.hblnk !== 1'b0 || out0.hsync !== 1'b0) begin n_err++;
      $display("FAIL reset hblnk/hsync: got %b%b want 00", out0.hblnk, out0.hsync); end
    n_chk++; if (addr0 !== 12'h000) begin n_err++;
      $display("FAIL reset pixel_addr: got %h want 000", addr0); end
    repeat (2) @(negedge clk);
    n_chk++; if (out2.rgb !== 12'h000) begin n_err++;
      $display("FAIL reset rgb2: got %h want 000", out2.rgb); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t vec [8];
    vec = '{
      '{100, 200, 1'b1, 12'h800},
      '{147, 263, 1'b1, 12'h7EF},
      '{148, 200, 1'b0, 12'h000},
      '{147, 200, 1'b1, 12'h82F},
      '{ 99, 200, 1'b0, 12'h000},
      '{100, 264, 1'b0, 12'h000},
      '{100, 199, 1'b0, 12'h000},
      '{101, 201, 1'b1, 12'h841}
    };
    x_pos = 100; y_pos = 200;
    sprite_en = 1'b1; mirror_x = 1'b0;
    latch_frame();
    for (int i = 0; i < 11; i++) begin
      if (i >= 3) begin
        int j;
        logic [11:0] e;
        j = i - 3;
        e = vec[j].hit ? vec[j].e : 12'(12'h0A0 + j);
        n_chk++; if (out0.rgb !== e) begin n_err++;
          $display("FAIL basic rgb[%0d]: got %h want %h", j, out0.rgb, e); end
        n_chk++; if (out0.hcount !== 11'(vec[j].h)) begin n_err++;
          $display("FAIL basic hcount[%0d]: got %0d want %0d", j, out0.hcount, vec[j].h); end
      end
      if (i < 8)
        drive(vec[i].h, vec[i].v, 1'b0, 1'b0, 12'(12'h0A0 + i));
      else
        drive(1100, 0, 1'b1, 1'b0, 12'h000);
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    drive(50, 50, 1'b0, 1'b0, 12'h111);
    repeat (5) @(negedge clk);
    drive(100, 200, 1'b0, 1'b0, 12'h222);
    repeat (2) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h111) begin n_err++;
      $display("FAIL lat3 early: got %h want 111", out0.rgb); end
    @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h800) begin n_err++;
      $display("FAIL lat3 edge: got %h want 800", out0.rgb); end
    @(negedge clk);
    n_chk++; if (out2.rgb !== 12'h111) begin n_err++;
      $display("FAIL lat5 early: got %h want 111", out2.rgb); end
    @(negedge clk);
    n_chk++; if (out2.rgb !== 12'h800) begin n_err++;
      $display("FAIL lat5 edge: got %h want 800", out2.rgb); end
    n_chk++; if (out2.hcount !== 11'd100) begin n_err++;
      $display("FAIL lat5 hcount: got %0d want 100", out2.hcount); end
  endtask

  task automatic test_key();
    drive(115, 228, 1'b0, 1'b0, 12'h3C3);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h3C3) begin n_err++;
      $display("FAIL key F0F: got %h want 3C3", out0.rgb); end
    repeat (2) @(negedge clk);
    n_chk++; if (out2.rgb !== 12'h3C3) begin n_err++;
      $display("FAIL key F0F lat5: got %h want 3C3", out2.rgb); end
    drive(114, 228, 1'b0, 1'b0, 12'h3C3);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'hF0E) begin n_err++;
      $display("FAIL key F0E: got %h want F0E", out0.rgb); end
  endtask

  task automatic test_frame_latch();
    x_pos = 100; y_pos = 380;
    latch_frame();
    drive(100, 400, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'hD00) begin n_err++;
      $display("FAIL tear base: got %h want D00", out0.rgb); end
    x_pos = 300;
    drive(100, 401, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'hD40) begin n_err++;
      $display("FAIL tear old x: got %h want D40", out0.rgb); end
    drive(300, 401, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h0F0) begin n_err++;
      $display("FAIL tear new x early: got %h want 0F0", out0.rgb); end
    latch_frame();
    drive(300, 400, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'hD00) begin n_err++;
      $display("FAIL next frame x300: got %h want D00", out0.rgb); end
    drive(100, 400, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h0F0) begin n_err++;
      $display("FAIL next frame x100: got %h want 0F0", out0.rgb); end
  endtask

  task automatic test_scale_mirror();
    vec_t vec [7];
    logic [11:0] ea [7];
    vec = '{
      '{  0,   0, 1'b1, 12'h82F},
      '{  1,   0, 1'b1, 12'h82F},
      '{  2,   0, 1'b1, 12'h82E},
      '{ 95,   0, 1'b1, 12'h800},
      '{ 96,   0, 1'b0, 12'h000},
      '{  0, 127, 1'b1, 12'h7EF},
      '{  0, 128, 1'b0, 12'h000}
    };
    ea = '{12'h02F, 12'h02F, 12'h02E, 12'h000,
           12'h000, 12'hFEF, 12'hFEF};
    x_pos = 0; y_pos = 0;
    mirror_x = 1'b1;
    latch_frame();
    for (int i = 0; i < 7; i++) begin
      logic [11:0] e;
      e = vec[i].hit ? vec[i].e : 12'h345;
      drive(vec[i].h, vec[i].v, 1'b0, 1'b0, 12'h345);
      @(negedge clk);
      n_chk++; if (addr1 !== ea[i]) begin n_err++;
        $display("FAIL zoom addr[%0d]: got %h want %h", i, addr1, ea[i]); end
      repeat (2) @(negedge clk);
      n_chk++; if (out1.rgb !== e) begin n_err++;
        $display("FAIL zoom rgb[%0d]: got %h want %h", i, out1.rgb, e); end
    end
    mirror_x = 1'b0;
  endtask

  task automatic test_clip();
    x_pos = 1000; y_pos = 200;
    latch_frame();
    drive(1000, 200, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h800) begin n_err++;
      $display("FAIL clip left: got %h want 800", out0.rgb); end
    drive(1023, 263, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h7D7) begin n_err++;
      $display("FAIL clip col1023: got %h want 7D7", out0.rgb); end
    drive(0, 200, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h0F0) begin n_err++;
      $display("FAIL clip wrap: got %h want 0F0", out0.rgb); end
    drive(1010, 200, 1'b1, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h000) begin n_err++;
      $display("FAIL hblnk in hit: got %h want 000", out0.rgb); end
    n_chk++; if (out0.hsync !== 1'b1) begin n_err++;
      $display("FAIL hsync delay: got %b want 1", out0.hsync); end
  endtask

  task automatic test_reset_mid();
    drive(1000, 200, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h800) begin n_err++;
      $display("FAIL pre-reset: got %h want 800", out0.rgb); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out0.rgb !== 12'h000) begin n_err++;
      $display("FAIL async rgb: got %h want 000", out0.rgb); end
    n_chk++; if (out0.hcount !== 11'd0 || out0.vcount !== 11'd0) begin n_err++;
      $display("FAIL async count: got %0d,%0d want 0,0", out0.hcount, out0.vcount); end
    n_chk++; if (addr0 !== 12'h000) begin n_err++;
      $display("FAIL async addr: got %h want 000", addr0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h0F0) begin n_err++;
      $display("FAIL hidden after reset: got %h want 0F0", out0.rgb); end
    n_chk++; if (out0.hcount !== 11'd1000) begin n_err++;
      $display("FAIL hcount after reset: got %0d want 1000", out0.hcount); end
    latch_frame();
    drive(1000, 200, 1'b0, 1'b0, 12'h0F0);
    repeat (3) @(negedge clk);
    n_chk++; if (out0.rgb !== 12'h800) begin n_err++;
      $display("FAIL relatch: got %h want 800", out0.rgb); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_key();
    test_frame_latch();
    test_scale_mirror();
    test_clip();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
